// File: rtl/bus_rr_xbar.sv
// Round-robin host/device bus: NrHosts hosts share one channel to NrDevices devices.
// Optional response timeout guarded by BUS_TIMEOUT_EN.
module bus_rr_xbar #(
    parameter int NrHosts       = 2,
    parameter int NrDevices     = 3,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NrHosts-1:0]                      host_req_i,
    output logic [NrHosts-1:0]                      host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
    input  logic [NrHosts-1:0]                      host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
    output logic [NrHosts-1:0]                      host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
    output logic [NrHosts-1:0]                      host_err_o,
    output logic [NrDevices-1:0]                    device_req_o,
    output logic [NrDevices-1:0][AddressWidth-1:0]  device_addr_o,
    output logic [NrDevices-1:0]                    device_we_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]   device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]     device_wdata_o,
    input  logic [NrDevices-1:0]                    device_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata_i,
    input  logic [NrDevices-1:0]                    device_err_i,
    input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_mask
);

    localparam int HW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DEV,
        ERR_RESP
    } state_t;

    state_t        state, state_n;
    logic [HW-1:0] owner, owner_n;
    logic [HW-1:0] rr_ptr, rr_n;
    logic [DW-1:0] target, target_n;

    logic          win_valid;
    logic [HW-1:0] win;
    logic          hit;
    logic [DW-1:0] dev;
    logic          window;
    logic          grant;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        for (int i = 0; i < NrHosts; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NrHosts;
            if (!win_valid && host_req_i[idx]) begin
                win_valid = 1'b1;
                win       = HW'(idx);
            end
        end
    end

    // Lowest matching device wins when regions overlap.
    always_comb begin
        hit = 1'b0;
        dev = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!hit && ((host_addr_i[win] & cfg_device_addr_mask[d])
                         == cfg_device_addr_base[d])) begin
                hit = 1'b1;
                dev = DW'(d);
            end
        end
    end

    assign window = (state == IDLE) ||
                    ((state == WAIT_DEV) && device_rvalid_i[target]);
    assign grant  = window && win_valid;

    always_comb begin
        host_gnt_o   = '0;
        device_req_o = '0;
        if (grant) begin
            host_gnt_o[win] = 1'b1;
            if (hit) begin
                device_req_o[dev] = 1'b1;
            end
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_addr_o[d]  = host_addr_i[win];
            device_we_o[d]    = host_we_i[win];
            device_be_o[d]    = host_be_i[win];
            device_wdata_o[d] = host_wdata_i[win];
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        unique case (state)
            WAIT_DEV: begin
                host_rvalid_o[owner] = device_rvalid_i[target];
                host_err_o[owner]    = device_err_i[target];
                host_rdata_o[owner]  = device_rdata_i[target];
            end
            ERR_RESP: begin
                host_rvalid_o[owner] = 1'b1;
                host_err_o[owner]    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state == WAIT_DEV) && !device_rvalid_i[target] &&
                     (tmo_cnt == TW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (grant) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_DEV) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        target_n = target;
        rr_n     = rr_ptr;
        unique case (state)
            IDLE: ;
            WAIT_DEV: begin
                if (device_rvalid_i[target]) begin
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    // Owner gets the generated error response next cycle.
                    state_n = ERR_RESP;
                end
            end
            ERR_RESP: state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (grant) begin
            owner_n = win;
            rr_n    = (int'(win) == NrHosts - 1) ? '0 : win + 1'b1;
            if (hit) begin
                state_n  = WAIT_DEV;
                target_n = dev;
            end else begin
                state_n  = ERR_RESP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            owner  <= '0;
            target <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            target <= target_n;
            rr_ptr <= rr_n;
        end
    end

endmodule
